// File: rtl/sys_ctrl_burst.sv
// sys_ctrl_burst: command-frame controller sitting between UART RX, the
// register file, the ALU and UART TX. Decodes single and burst register
// accesses plus ALU commands, queues response bytes in a small TX FIFO,
// and flags malformed/timed-out frames with a one-cycle Frame_Err pulse.
module sys_ctrl_burst #(
    parameter int width     = 8,
    parameter int depth     = 16,
    parameter int TXQ_DEPTH = 8,
    parameter int TIMEOUT   = 4096
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic [width-1:0]         Rx_P_Data,
    input  logic                     RxValid,
    input  logic [2*width-1:0]       ALU_out,
    input  logic                     ALU_out_valid,
    output logic                     ALU_EN,
    output logic [3:0]               ALU_FUN,
    input  logic [width-1:0]         RdData,
    input  logic                     Rd_valid,
    output logic [$clog2(depth)-1:0] Reg_File_Adress,
    output logic                     WrEN,
    output logic                     RdEN,
    output logic [width-1:0]         WrData,
    input  logic                     Busy,
    input  logic                     can_send,
    output logic [width-1:0]         Tx_Data,
    output logic                     Tx_Data_valid,
    output logic                     CLK_GATE_EN,
    output logic                     Frame_Err
);
    localparam int AW = $clog2(depth);
    localparam int QW = $clog2(TXQ_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [width-1:0] OP_WR  = width'(8'hAA);
    localparam logic [width-1:0] OP_RD  = width'(8'hBB);
    localparam logic [width-1:0] OP_ALU = width'(8'hCC);
    localparam logic [width-1:0] OP_ALN = width'(8'hDD);
    localparam logic [width-1:0] OP_BW  = width'(8'hEE);
    localparam logic [width-1:0] OP_BR  = width'(8'hEF);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_F, ALU_WAIT,
        BW_ADDR, BW_CNT, BW_DATA, BR_ADDR, BR_CNT, BR_ISSUE, BR_WAIT
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [AW-1:0]     r_addr, w_addr_nxt;
    logic [width-1:0]  r_cnt, w_cnt_nxt;
    logic              r_pend, w_pend_nxt;     // command accepted, strobe held back for FIFO room
    logic [TW-1:0]     r_to_cnt;

    logic              r_wr_en, w_wr_en_nxt;
    logic              r_rd_en, w_rd_en_nxt;
    logic              r_alu_en, w_alu_en_nxt;
    logic              r_err, w_err_nxt;
    logic [width-1:0]  r_wr_data, w_wr_data_nxt;
    logic [AW-1:0]     r_rf_addr, w_rf_addr_nxt;
    logic [3:0]        r_alu_fun, w_alu_fun_nxt;
    logic              r_gate;

    logic              w_rd_push, w_alu_push;
    logic              w_collect, w_timeout;
    logic [AW-1:0]     w_rx_addr;

    // TX FIFO; pointers carry one extra wrap bit so full/empty are distinguishable
    logic [width-1:0]  r_mem [TXQ_DEPTH];
    logic [QW:0]       r_wptr, r_rptr;
    logic              r_hi_pend;              // upper ALU byte waits one cycle behind the lower
    logic [width-1:0]  r_hi_byte;
    logic              r_tx_arm, r_busy_seen;
    logic [QW:0]       w_count, w_free;
    logic              w_empty, w_full, w_room1, w_room2;
    logic              w_push_req, w_push, w_pop;
    logic [width-1:0]  w_push_data;

    assign w_rx_addr = Rx_P_Data[AW-1:0];
    assign w_count   = r_wptr - r_rptr;
    assign w_empty   = (w_count == '0);
    assign w_full    = (w_count == (QW+1)'(TXQ_DEPTH));
    // a pending upper ALU byte already owns a slot
    assign w_free    = (QW+1)'(TXQ_DEPTH) - w_count - (QW+1)'(r_hi_pend);
    assign w_room1   = (w_free >= (QW+1)'(1));
    assign w_room2   = (w_free >= (QW+1)'(2));

    assign w_collect = r_state inside {WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_F,
                                       BW_ADDR, BW_CNT, BW_DATA, BR_ADDR, BR_CNT};
    assign w_timeout = w_collect && !RxValid && (r_to_cnt == TW'(TIMEOUT - 1));

    // Next-state, command strobes and FIFO push requests
    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_cnt_nxt     = r_cnt;
        w_pend_nxt    = r_pend;
        w_wr_en_nxt   = 1'b0;
        w_rd_en_nxt   = 1'b0;
        w_alu_en_nxt  = 1'b0;
        w_err_nxt     = 1'b0;
        w_wr_data_nxt = r_wr_data;
        w_rf_addr_nxt = r_rf_addr;
        w_alu_fun_nxt = r_alu_fun;
        w_rd_push     = 1'b0;
        w_alu_push    = 1'b0;
        case (r_state)
            IDLE: if (RxValid) begin
                case (Rx_P_Data)
                    OP_WR:   w_state_nxt = WR_ADDR;
                    OP_RD:   w_state_nxt = RD_ADDR;
                    OP_ALU:  w_state_nxt = ALU_A;
                    OP_ALN:  w_state_nxt = ALU_F;
                    OP_BW:   w_state_nxt = BW_ADDR;
                    OP_BR:   w_state_nxt = BR_ADDR;
                    default: w_err_nxt   = 1'b1;
                endcase
            end
            WR_ADDR: if (RxValid) begin
                w_addr_nxt  = w_rx_addr;
                w_state_nxt = WR_DATA;
            end
            WR_DATA: if (RxValid) begin
                w_wr_en_nxt   = 1'b1;
                w_wr_data_nxt = Rx_P_Data;
                w_rf_addr_nxt = r_addr;
                w_state_nxt   = IDLE;
            end
            RD_ADDR: if (RxValid) begin
                w_addr_nxt  = w_rx_addr;
                w_state_nxt = RD_WAIT;
                if (w_room1) begin
                    w_rd_en_nxt   = 1'b1;
                    w_rf_addr_nxt = w_rx_addr;
                    w_pend_nxt    = 1'b0;
                end else begin
                    w_pend_nxt    = 1'b1;
                end
            end
            RD_WAIT: begin
                w_err_nxt = RxValid;
                if (r_pend) begin
                    if (w_room1) begin
                        w_rd_en_nxt   = 1'b1;
                        w_rf_addr_nxt = r_addr;
                        w_pend_nxt    = 1'b0;
                    end
                end else if (Rd_valid) begin
                    w_rd_push   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            ALU_A: if (RxValid) begin
                w_wr_en_nxt   = 1'b1;
                w_wr_data_nxt = Rx_P_Data;
                w_rf_addr_nxt = AW'(0);
                w_state_nxt   = ALU_B;
            end
            ALU_B: if (RxValid) begin
                w_wr_en_nxt   = 1'b1;
                w_wr_data_nxt = Rx_P_Data;
                w_rf_addr_nxt = AW'(1);
                w_state_nxt   = ALU_F;
            end
            ALU_F: if (RxValid) begin
                w_alu_fun_nxt = Rx_P_Data[3:0];
                w_state_nxt   = ALU_WAIT;
                if (w_room2) begin
                    w_alu_en_nxt = 1'b1;
                    w_pend_nxt   = 1'b0;
                end else begin
                    w_pend_nxt   = 1'b1;
                end
            end
            ALU_WAIT: begin
                w_err_nxt = RxValid;
                if (r_pend) begin
                    if (w_room2) begin
                        w_alu_en_nxt = 1'b1;
                        w_pend_nxt   = 1'b0;
                    end
                end else if (ALU_out_valid) begin
                    w_alu_push  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            BW_ADDR: if (RxValid) begin
                w_addr_nxt  = w_rx_addr;
                w_state_nxt = BW_CNT;
            end
            BW_CNT: if (RxValid) begin
                w_cnt_nxt   = Rx_P_Data;
                w_state_nxt = (Rx_P_Data == '0) ? IDLE : BW_DATA;
            end
            BW_DATA: if (RxValid) begin
                w_wr_en_nxt   = 1'b1;
                w_wr_data_nxt = Rx_P_Data;
                w_rf_addr_nxt = r_addr;
                w_addr_nxt    = r_addr + 1'b1;
                w_cnt_nxt     = r_cnt - 1'b1;
                if (r_cnt == width'(1)) w_state_nxt = IDLE;
            end
            BR_ADDR: if (RxValid) begin
                w_addr_nxt  = w_rx_addr;
                w_state_nxt = BR_CNT;
            end
            BR_CNT: if (RxValid) begin
                w_cnt_nxt   = Rx_P_Data;
                w_state_nxt = (Rx_P_Data == '0) ? IDLE : BR_ISSUE;
            end
            BR_ISSUE: begin
                w_err_nxt = RxValid;
                if (w_room1) begin
                    w_rd_en_nxt   = 1'b1;
                    w_rf_addr_nxt = r_addr;
                    w_state_nxt   = BR_WAIT;
                end
            end
            BR_WAIT: begin
                w_err_nxt = RxValid;
                if (Rd_valid) begin
                    w_rd_push   = 1'b1;
                    w_addr_nxt  = r_addr + 1'b1;
                    w_cnt_nxt   = r_cnt - 1'b1;
                    w_state_nxt = (r_cnt == width'(1)) ? IDLE : BR_ISSUE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // a stalled frame is abandoned silently apart from the error pulse
        if (w_timeout) begin
            w_state_nxt = IDLE;
            w_err_nxt   = 1'b1;
            w_pend_nxt  = 1'b0;
        end
    end

    // FSM state and registered command outputs
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_pend    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_alu_en  <= 1'b0;
            r_err     <= 1'b0;
            r_wr_data <= '0;
            r_rf_addr <= '0;
            r_alu_fun <= '0;
            r_gate    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pend    <= w_pend_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_alu_en  <= w_alu_en_nxt;
            r_err     <= w_err_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_rf_addr <= w_rf_addr_nxt;
            r_alu_fun <= w_alu_fun_nxt;
            r_gate    <= (w_state_nxt == ALU_F) || (w_state_nxt == ALU_WAIT);
        end
    end

    // Inter-byte idle counter, only live while a frame is being collected
    always_ff @(posedge CLK) begin
        if (!Reset || !w_collect || RxValid) r_to_cnt <= '0;
        else                                 r_to_cnt <= r_to_cnt + 1'b1;
    end

    assign w_push_req  = w_rd_push | w_alu_push | r_hi_pend;
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_push_data = w_rd_push  ? RdData :
                         w_alu_push ? ALU_out[width-1:0] : r_hi_byte;
    assign w_pop       = r_tx_arm && !w_empty && !Busy && can_send;

    // FIFO storage needs no reset; contents are only visible through pops
    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wptr[QW-1:0]] <= w_push_data;
    end

    // FIFO pointers and the deferred upper ALU byte
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_hi_pend <= 1'b0;
            r_hi_byte <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_hi_pend <= w_alu_push;
            if (w_alu_push) r_hi_byte <= ALU_out[2*width-1:width];
        end
    end

    // After each pop, wait for the serialiser to go busy and idle again
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_tx_arm    <= 1'b1;
            r_busy_seen <= 1'b0;
        end else if (w_pop) begin
            r_tx_arm    <= 1'b0;
            r_busy_seen <= 1'b0;
        end else if (!r_tx_arm) begin
            if (Busy)             r_busy_seen <= 1'b1;
            else if (r_busy_seen) r_tx_arm    <= 1'b1;
        end
    end

    assign WrEN            = r_wr_en;
    assign RdEN            = r_rd_en;
    assign ALU_EN          = r_alu_en;
    assign ALU_FUN         = r_alu_fun;
    assign WrData          = r_wr_data;
    assign Reg_File_Adress = r_rf_addr;
    assign Frame_Err       = r_err;
    assign CLK_GATE_EN     = r_gate;
    assign Tx_Data_valid   = w_pop;
    assign Tx_Data         = w_pop ? r_mem[r_rptr[QW-1:0]] : '0;

endmodule
